// File: rtl/calc1.sv
// calc1: four-port 32-bit unsigned calculator.
// Each port runs its own request FSM (IDLE -> OP2 -> PEND -> EXEC -> RESP).
// The ports share one add/subtract unit and one shift unit. Each unit grants
// one pending port per cycle, lowest port number first.
module calc1 (
    input  logic        c_clk,
    input  logic [1:7]  reset,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req4_data_in,
    output logic [0:31] out_data1,
    output logic [0:1]  out_resp1,
    output logic [0:31] out_data2,
    output logic [0:1]  out_resp2,
    output logic [0:31] out_data3,
    output logic [0:1]  out_resp3,
    output logic [0:31] out_data4,
    output logic [0:1]  out_resp4
);

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_OVF  = 2'd2;
    localparam logic [1:0] RESP_INV  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP2,
        ST_PEND,
        ST_EXEC,
        ST_RESP
    } state_t;

    // Only the first reset bit is functional; the rest may legitimately be X.
    logic srst;
    logic unused_reset;
    assign srst         = reset[1];
    assign unused_reset = ^reset[2:7];

    // Per-port views of the flat port list, indexed 0..3 for ports 1..4.
    logic [3:0]  cmd_in  [4];
    logic [31:0] data_in [4];
    logic [31:0] op1_arr [4];
    logic [31:0] op2_arr [4];
    logic [3:0]  opc_arr [4];
    logic [31:0] dout_arr[4];
    logic [1:0]  resp_arr[4];

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    assign out_data1 = dout_arr[0];
    assign out_data2 = dout_arr[1];
    assign out_data3 = dout_arr[2];
    assign out_data4 = dout_arr[3];
    assign out_resp1 = resp_arr[0];
    assign out_resp2 = resp_arr[1];
    assign out_resp3 = resp_arr[2];
    assign out_resp4 = resp_arr[3];

    // Pending / executing flags per unit, one bit per port.
    logic [3:0] pend_as;
    logic [3:0] pend_sh;
    logic [3:0] exec_as;
    logic [3:0] exec_sh;
    logic [3:0] grant_as;
    logic [3:0] grant_sh;

    // Fixed priority: isolate the lowest set bit of each pending vector.
    assign grant_as = pend_as & (~pend_as + 4'd1);
    assign grant_sh = pend_sh & (~pend_sh + 4'd1);

    // Shared unit results, consumed by whichever port sits in EXEC.
    logic [31:0] as_a;
    logic [31:0] as_b;
    logic        as_sub;
    logic [32:0] as_sum;
    logic [1:0]  as_resp_d;
    logic [31:0] as_data_d;
    logic [31:0] sh_a;
    logic [4:0]  sh_amt;
    logic        sh_left;
    logic [31:0] sh_data_d;

    // Add/subtract unit: operand mux from the executing port, then compute.
    always_comb begin
        as_a   = 32'd0;
        as_b   = 32'd0;
        as_sub = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (exec_as[i]) begin
                as_a   = op1_arr[i];
                as_b   = op2_arr[i];
                as_sub = (opc_arr[i] == CMD_SUB);
            end
        end
        as_sum    = {1'b0, as_a} + {1'b0, as_b};
        as_resp_d = RESP_OK;
        as_data_d = as_sum[31:0];
        if (as_sub) begin
            if (as_b > as_a) begin
                as_resp_d = RESP_OVF;
                as_data_d = 32'hFFFF_FFFF;
            end else begin
                as_data_d = as_a - as_b;
            end
        end else if (as_sum[32]) begin
            as_resp_d = RESP_OVF;
            as_data_d = 32'hFFFF_FFFF;
        end
    end

    // Shift unit: amount is the low five bits of op2, zero fill, never overflows.
    always_comb begin
        sh_a    = 32'd0;
        sh_amt  = 5'd0;
        sh_left = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (exec_sh[i]) begin
                sh_a    = op1_arr[i];
                sh_amt  = op2_arr[i][4:0];
                sh_left = (opc_arr[i] == CMD_SHL);
            end
        end
        sh_data_d = sh_left ? (sh_a << sh_amt) : (sh_a >> sh_amt);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_port
            state_t      state_q;
            logic [3:0]  cmd_q;
            logic [31:0] op1_q;
            logic [31:0] op2_q;
            logic [31:0] data_q;
            logic [1:0]  resp_q;
            logic        is_as;
            logic        is_sh;

            assign is_as = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB);
            assign is_sh = (cmd_q == CMD_SHL) || (cmd_q == CMD_SHR);

            assign pend_as[gi] = (state_q == ST_PEND) && is_as;
            assign pend_sh[gi] = (state_q == ST_PEND) && is_sh;
            assign exec_as[gi] = (state_q == ST_EXEC) && is_as;
            assign exec_sh[gi] = (state_q == ST_EXEC) && is_sh;

            assign op1_arr[gi]  = op1_q;
            assign op2_arr[gi]  = op2_q;
            assign opc_arr[gi]  = cmd_q;
            assign dout_arr[gi] = data_q;
            assign resp_arr[gi] = resp_q;

            // Request FSM with registered response; response defaults to none so it lasts one cycle.
            always_ff @(posedge c_clk) begin
                if (srst) begin
                    state_q <= ST_IDLE;
                    cmd_q   <= CMD_NOP;
                    op1_q   <= 32'd0;
                    op2_q   <= 32'd0;
                    data_q  <= 32'd0;
                    resp_q  <= RESP_NONE;
                end else begin
                    data_q <= 32'd0;
                    resp_q <= RESP_NONE;
                    case (state_q)
                        ST_IDLE: begin
                            if (cmd_in[gi] != CMD_NOP) begin
                                cmd_q   <= cmd_in[gi];
                                op1_q   <= data_in[gi];
                                state_q <= ST_OP2;
                            end
                        end
                        ST_OP2: begin
                            op2_q   <= data_in[gi];
                            state_q <= ST_PEND;
                        end
                        ST_PEND: begin
                            if (!is_as && !is_sh) begin
                                resp_q  <= RESP_INV;
                                state_q <= ST_RESP;
                            end else if ((is_as && grant_as[gi]) || (is_sh && grant_sh[gi])) begin
                                state_q <= ST_EXEC;
                            end
                        end
                        ST_EXEC: begin
                            if (is_as) begin
                                resp_q <= as_resp_d;
                                data_q <= as_data_d;
                            end else begin
                                resp_q <= RESP_OK;
                                data_q <= sh_data_d;
                            end
                            state_q <= ST_RESP;
                        end
                        ST_RESP: begin
                            state_q <= ST_IDLE;
                        end
                        default: begin
                            state_q <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_calc1.sv
// Directed self-checking bench for calc1. Inputs are driven and outputs sampled
// on the falling clock edge; cycle k means the k-th falling edge after the
// command was driven (cycle 0).
module tb_calc1;

    logic c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    logic [1:7]  reset;
    logic [3:0]  cmd_v  [4];
    logic [31:0] data_v [4];
    logic [31:0] op2_v  [4];

    wire [0:31] out_data1, out_data2, out_data3, out_data4;
    wire [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;

    logic [1:0]  resp_w [4];
    logic [31:0] dout_w [4];
    assign resp_w[0] = out_resp1;
    assign resp_w[1] = out_resp2;
    assign resp_w[2] = out_resp3;
    assign resp_w[3] = out_resp4;
    assign dout_w[0] = out_data1;
    assign dout_w[1] = out_data2;
    assign dout_w[2] = out_data3;
    assign dout_w[3] = out_data4;

    calc1 dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .req1_cmd_in  (cmd_v[0]),
        .req1_data_in (data_v[0]),
        .req2_cmd_in  (cmd_v[1]),
        .req2_data_in (data_v[1]),
        .req3_cmd_in  (cmd_v[2]),
        .req3_data_in (data_v[2]),
        .req4_cmd_in  (cmd_v[3]),
        .req4_data_in (data_v[3]),
        .out_data1    (out_data1),
        .out_resp1    (out_resp1),
        .out_data2    (out_data2),
        .out_resp2    (out_resp2),
        .out_data3    (out_data3),
        .out_resp3    (out_resp3),
        .out_data4    (out_data4),
        .out_resp4    (out_resp4)
    );

    int total = 0;
    int bad   = 0;

    // Observations from the last transaction window.
    int          first_cyc [4];
    int          cnt       [4];
    logic [1:0]  resp_s    [4];
    logic [31:0] data_s    [4];
    int          zero_bad;

    task automatic put(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        cmd_v[p]  = c;
        data_v[p] = a;
        op2_v[p]  = b;
    endtask

    // Drives op2 on cycle 1, then records responses over cycles 3..12.
    task automatic run_txn();
        @(negedge c_clk);
        for (int i = 0; i < 4; i++) begin
            data_v[i] = op2_v[i];
            cmd_v[i]  = 4'd0;
        end
        @(negedge c_clk);
        for (int i = 0; i < 4; i++) begin
            data_v[i]    = 32'd0;
            op2_v[i]     = 32'd0;
            first_cyc[i] = -1;
            cnt[i]       = 0;
            resp_s[i]    = 2'd0;
            data_s[i]    = 32'd0;
        end
        zero_bad = 0;
        for (int k = 3; k <= 12; k++) begin
            @(negedge c_clk);
            for (int p = 0; p < 4; p++) begin
                if (resp_w[p] !== 2'd0) begin
                    if (first_cyc[p] < 0) begin
                        first_cyc[p] = k;
                        resp_s[p]    = resp_w[p];
                        data_s[p]    = dout_w[p];
                    end
                    cnt[p]++;
                end else if (dout_w[p] !== 32'd0) begin
                    zero_bad++;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 7'b1xxxxxx;
        put(0, 4'd1, 32'd5, 32'd6);
        repeat (3) @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin
            total++;
            if (resp_w[p] !== 2'd0 || dout_w[p] !== 32'd0) begin
                bad++;
                $display("FAIL reset_out port%0d resp=%0d data=%h want resp=0 data=0", p + 1, resp_w[p], dout_w[p]);
            end
        end
        cmd_v[0] = 4'd0;
        data_v[0] = 32'd0;
        reset = 7'b0xxxxxx;
        @(negedge c_clk);
        total++;
        if (resp_w[0] !== 2'd0) begin
            bad++;
            $display("FAIL reset_cmd_ignored resp=%0d want=0", resp_w[0]);
        end
    endtask

    task automatic test_shift();
        int          ec [4] = '{4, 5, 6, -1};
        logic [31:0] ed [4] = '{32'hFFFF_FFF8, 32'h0000_0001, 32'h1234_5678, 32'h0};
        put(0, 4'd5, 32'h1FFF_FFFF, 32'd3);
        put(1, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        put(2, 4'd5, 32'h1234_5678, 32'h0000_0020);
        run_txn();
        for (int p = 0; p < 4; p++) begin
            total++;
            if (cnt[p] !== ((ec[p] > 0) ? 1 : 0)) begin
                bad++;
                $display("FAIL shift_count port%0d got=%0d want=%0d", p + 1, cnt[p], (ec[p] > 0) ? 1 : 0);
            end
            if (ec[p] > 0) begin
                total += 3;
                if (first_cyc[p] !== ec[p]) begin bad++; $display("FAIL shift_cycle port%0d got=%0d want=%0d", p + 1, first_cyc[p], ec[p]); end
                if (resp_s[p] !== 2'd1) begin bad++; $display("FAIL shift_resp port%0d got=%0d want=1", p + 1, resp_s[p]); end
                if (data_s[p] !== ed[p]) begin bad++; $display("FAIL shift_data port%0d got=%h want=%h", p + 1, data_s[p], ed[p]); end
            end
        end
        total++;
        if (zero_bad !== 0) begin bad++; $display("FAIL shift_zero_data got=%0d want=0", zero_bad); end
    endtask

    task automatic test_sub_zero();
        for (int q = 0; q < 5; q++) begin
            int          port = (q == 4) ? 0 : q;
            logic [31:0] a    = (q == 4) ? 32'd0 : 32'h0000_8000;
            put(port, 4'd2, a, 32'd0);
            run_txn();
            for (int p = 0; p < 4; p++) begin
                total++;
                if (cnt[p] !== ((p == port) ? 1 : 0)) begin
                    bad++;
                    $display("FAIL subz_count case%0d port%0d got=%0d want=%0d", q, p + 1, cnt[p], (p == port) ? 1 : 0);
                end
            end
            total += 3;
            if (first_cyc[port] !== 4) begin bad++; $display("FAIL subz_cycle case%0d got=%0d want=4", q, first_cyc[port]); end
            if (resp_s[port] !== 2'd1) begin bad++; $display("FAIL subz_resp case%0d got=%0d want=1", q, resp_s[port]); end
            if (data_s[port] !== a) begin bad++; $display("FAIL subz_data case%0d got=%h want=%h", q, data_s[port], a); end
        end
    endtask

    task automatic test_underflow();
        for (int port = 0; port < 4; port++) begin
            put(port, 4'd2, 32'h0008_0000, 32'h0010_0000);
            run_txn();
            total += 4;
            if (cnt[port] !== 1) begin bad++; $display("FAIL unf_count port%0d got=%0d want=1", port + 1, cnt[port]); end
            if (first_cyc[port] !== 4) begin bad++; $display("FAIL unf_cycle port%0d got=%0d want=4", port + 1, first_cyc[port]); end
            if (resp_s[port] !== 2'd2) begin bad++; $display("FAIL unf_resp port%0d got=%0d want=2", port + 1, resp_s[port]); end
            if (data_s[port] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL unf_data port%0d got=%h want=ffffffff", port + 1, data_s[port]); end
        end
    endtask

    task automatic test_add_boundary();
        put(0, 4'd1, 32'hFFFF_FFFF, 32'd1);
        put(1, 4'd1, 32'hFFFF_FFFE, 32'd1);
        run_txn();
        total += 8;
        if (cnt[0] !== 1) begin bad++; $display("FAIL addovf_count got=%0d want=1", cnt[0]); end
        if (first_cyc[0] !== 4) begin bad++; $display("FAIL addovf_cycle got=%0d want=4", first_cyc[0]); end
        if (resp_s[0] !== 2'd2) begin bad++; $display("FAIL addovf_resp got=%0d want=2", resp_s[0]); end
        if (data_s[0] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL addovf_data got=%h want=ffffffff", data_s[0]); end
        if (cnt[1] !== 1) begin bad++; $display("FAIL addmax_count got=%0d want=1", cnt[1]); end
        if (first_cyc[1] !== 5) begin bad++; $display("FAIL addmax_cycle got=%0d want=5", first_cyc[1]); end
        if (resp_s[1] !== 2'd1) begin bad++; $display("FAIL addmax_resp got=%0d want=1", resp_s[1]); end
        if (data_s[1] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL addmax_data got=%h want=ffffffff", data_s[1]); end
    endtask

    task automatic test_contention();
        // Case 0: four adds. Case 1: three adds plus a shift on port 4.
        for (int c = 0; c < 2; c++) begin
            int ec [4];
            for (int p = 0; p < 4; p++) put(p, 4'd1, 32'd1, 32'd1);
            if (c == 1) put(3, 4'd5, 32'd1, 32'd1);
            ec[0] = 4; ec[1] = 5; ec[2] = 6; ec[3] = (c == 0) ? 7 : 4;
            run_txn();
            for (int p = 0; p < 4; p++) begin
                total += 4;
                if (cnt[p] !== 1) begin bad++; $display("FAIL cont%0d_count port%0d got=%0d want=1", c, p + 1, cnt[p]); end
                if (first_cyc[p] !== ec[p]) begin bad++; $display("FAIL cont%0d_cycle port%0d got=%0d want=%0d", c, p + 1, first_cyc[p], ec[p]); end
                if (resp_s[p] !== 2'd1) begin bad++; $display("FAIL cont%0d_resp port%0d got=%0d want=1", c, p + 1, resp_s[p]); end
                if (data_s[p] !== 32'd2) begin bad++; $display("FAIL cont%0d_data port%0d got=%h want=2", c, p + 1, data_s[p]); end
            end
            total++;
            if (zero_bad !== 0) begin bad++; $display("FAIL cont%0d_zero_data got=%0d want=0", c, zero_bad); end
        end
    endtask

    task automatic test_invalid();
        put(2, 4'd4, 32'hDEAD_BEEF, 32'h1234_5678);
        put(0, 4'd15, 32'h1111_1111, 32'h2222_2222);
        run_txn();
        total += 6;
        if (cnt[2] !== 1) begin bad++; $display("FAIL inv4_count got=%0d want=1", cnt[2]); end
        if (first_cyc[2] !== 3) begin bad++; $display("FAIL inv4_cycle got=%0d want=3", first_cyc[2]); end
        if (resp_s[2] !== 2'd3) begin bad++; $display("FAIL inv4_resp got=%0d want=3", resp_s[2]); end
        if (data_s[2] !== 32'd0) begin bad++; $display("FAIL inv4_data got=%h want=0", data_s[2]); end
        if (resp_s[0] !== 2'd3) begin bad++; $display("FAIL inv15_resp got=%0d want=3", resp_s[0]); end
        if (cnt[1] !== 0 || cnt[3] !== 0) begin bad++; $display("FAIL inv_others got=%0d/%0d want=0/0", cnt[1], cnt[3]); end
    endtask

    task automatic test_back_to_back();
        int extra = 0;
        put(1, 4'd1, 32'd5, 32'd3);          // cycle 0
        @(negedge c_clk);                    // cycle 1: op2
        data_v[1] = 32'd3;
        cmd_v[1]  = 4'd0;
        @(negedge c_clk);                    // cycle 2: busy, this command is ignored
        cmd_v[1]  = 4'd1;
        data_v[1] = 32'd7;
        @(negedge c_clk);                    // cycle 3
        cmd_v[1]  = 4'd0;
        data_v[1] = 32'd0;
        @(negedge c_clk);                    // cycle 4: response
        total += 2;
        if (resp_w[1] !== 2'd1) begin bad++; $display("FAIL b2b_first_resp got=%0d want=1", resp_w[1]); end
        if (dout_w[1] !== 32'd8) begin bad++; $display("FAIL b2b_first_data got=%h want=8", dout_w[1]); end
        @(negedge c_clk);                    // cycle 5: first cycle after response
        total++;
        if (resp_w[1] !== 2'd0) begin bad++; $display("FAIL b2b_gap_resp got=%0d want=0", resp_w[1]); end
        cmd_v[1]  = 4'd2;
        data_v[1] = 32'd9;
        @(negedge c_clk);
        cmd_v[1]  = 4'd0;
        data_v[1] = 32'd4;
        @(negedge c_clk);
        data_v[1] = 32'd0;
        repeat (2) @(negedge c_clk);         // cycle 9: second response
        total += 2;
        if (resp_w[1] !== 2'd1) begin bad++; $display("FAIL b2b_second_resp got=%0d want=1", resp_w[1]); end
        if (dout_w[1] !== 32'd5) begin bad++; $display("FAIL b2b_second_data got=%h want=5", dout_w[1]); end
        repeat (8) begin
            @(negedge c_clk);
            if (resp_w[1] !== 2'd0) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL b2b_ignored_cmd responses=%0d want=0", extra); end
    endtask

    task automatic test_reset_abort();
        int stray = 0;
        put(0, 4'd1, 32'd1, 32'd2);
        put(1, 4'd1, 32'd3, 32'd4);
        @(negedge c_clk);
        for (int i = 0; i < 4; i++) begin
            data_v[i] = op2_v[i];
            cmd_v[i]  = 4'd0;
        end
        @(negedge c_clk);                    // both ports now pending
        for (int i = 0; i < 4; i++) data_v[i] = 32'd0;
        reset = 7'b1xxxxxx;
        repeat (2) @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin
            total++;
            if (resp_w[p] !== 2'd0 || dout_w[p] !== 32'd0) begin
                bad++;
                $display("FAIL abort_in_reset port%0d resp=%0d data=%h want 0/0", p + 1, resp_w[p], dout_w[p]);
            end
        end
        reset = 7'b0xxxxxx;
        repeat (10) begin
            @(negedge c_clk);
            for (int p = 0; p < 4; p++)
                if (resp_w[p] !== 2'd0 || dout_w[p] !== 32'd0) stray++;
        end
        total++;
        if (stray !== 0) begin bad++; $display("FAIL abort_no_response got=%0d nonzero samples want=0", stray); end
    endtask

    initial begin
        reset = 7'b1xxxxxx;
        for (int i = 0; i < 4; i++) begin
            cmd_v[i]  = 4'd0;
            data_v[i] = 32'd0;
            op2_v[i]  = 32'd0;
        end
        @(negedge c_clk);
        test_reset();
        test_shift();
        test_sub_zero();
        test_underflow();
        test_add_boundary();
        test_contention();
        test_invalid();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
